// File: rtl/buffer_write_scheduler_pkg.sv
// Shared types for the operand-buffer write scheduler.
//   sched_state_t : scheduler FSM state encoding
//   SEL_A / SEL_B : buf_sel_o encodings for operand buffer A / B
package buffer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    DONE    = 2'd3
  } sched_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/buffer_write_scheduler_addr_counter.sv
// Write counter for one operand buffer.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_i      : zero the count (start of a job); wins over inc_i
//   inc_i        : one word was accepted for this buffer
//   count_o      : 16-bit words written this job, wraps modulo 2^16
//   addr_o       : low ADDR_WIDTH bits of the count (next write address)
//   half_o       : top address bit of the count; toggles every half wrap
module buffer_addr_counter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  inc_i,
  output logic [15:0]           count_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  half_o
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_i) begin
      count_o <= count_o + 16'd1;
    end
  end

  assign addr_o = count_o[ADDR_WIDTH-1:0];
  assign half_o = count_o[ADDR_WIDTH-1];

endmodule

// File: rtl/buffer_write_scheduler.sv
// Arbitrates loaders A and B onto one operand-buffer write port.
// Bursts of up to BURST_LEN words are granted round-robin, starting with A.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start_i, words_a/b_i    : job start (IDLE only) and per-buffer word counts
//   a_*/b_*                 : loader streams (valid/ready)
//   buf_we/sel/addr/wdata_o : registered buffer write, one cycle after handshake
//   count_a/b_o, half_a/b_o : per-buffer write count and half-buffer flag
//   busy_o, done_o          : job in progress, one-cycle end-of-job pulse
//   state_o                 : FSM state for observation
//
// Handshake: a transfer happens in any cycle where valid and ready are both
// high. ready depends only on registered state and remaining count, never on
// valid, and at most one ready is high at a time. A loader holding the grant
// with valid low keeps the grant until its burst ends.
module buffer_write_scheduler
  import buffer_sched_pkg::*;
#(
  parameter int BUFFER_ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH           = 32,
  parameter int BURST_LEN            = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start_i,
  input  logic [15:0]                     words_a_i,
  input  logic [15:0]                     words_b_i,
  input  logic                            a_valid_i,
  input  logic [DATA_WIDTH-1:0]           a_data_i,
  output logic                            a_ready_o,
  input  logic                            b_valid_i,
  input  logic [DATA_WIDTH-1:0]           b_data_i,
  output logic                            b_ready_o,
  output logic                            buf_we_o,
  output logic                            buf_sel_o,
  output logic [BUFFER_ADDRESS_WIDTH-1:0] buf_addr_o,
  output logic [DATA_WIDTH-1:0]           buf_wdata_o,
  output logic [15:0]                     count_a_o,
  output logic [15:0]                     count_b_o,
  output logic                            half_a_o,
  output logic                            half_b_o,
  output logic                            busy_o,
  output logic                            done_o,
  output sched_state_t                    state_o
);

  localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);

  sched_state_t                    state;
  logic [15:0]                     rem_a, rem_b, burst_cnt;
  logic [15:0]                     rem_next;
  logic                            hs_a, hs_b, start_job, burst_end;
  logic [BUFFER_ADDRESS_WIDTH-1:0] addr_a, addr_b;

  assign a_ready_o = (state == GRANT_A) && (rem_a != 16'd0);
  assign b_ready_o = (state == GRANT_B) && (rem_b != 16'd0);
  assign hs_a      = a_valid_i && a_ready_o;
  assign hs_b      = b_valid_i && b_ready_o;
  assign start_job = (state == IDLE) && start_i;
  assign busy_o    = (state != IDLE);
  assign state_o   = state;

  // Remaining count of the granted side after this cycle's transfer.
  always_comb begin
    rem_next  = (state == GRANT_B) ? (rem_b - 16'd1) : (rem_a - 16'd1);
    burst_end = (hs_a || hs_b) && ((burst_cnt == BURST_LAST) || (rem_next == 16'd0));
  end

  buffer_addr_counter #(.ADDR_WIDTH(BUFFER_ADDRESS_WIDTH)) u_cnt_a (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (start_job),
    .inc_i   (hs_a),
    .count_o (count_a_o),
    .addr_o  (addr_a),
    .half_o  (half_a_o)
  );

  buffer_addr_counter #(.ADDR_WIDTH(BUFFER_ADDRESS_WIDTH)) u_cnt_b (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (start_job),
    .inc_i   (hs_b),
    .count_o (count_b_o),
    .addr_o  (addr_b),
    .half_o  (half_b_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rem_a       <= '0;
      rem_b       <= '0;
      burst_cnt   <= '0;
      buf_we_o    <= 1'b0;
      buf_sel_o   <= SEL_A;
      buf_addr_o  <= '0;
      buf_wdata_o <= '0;
      done_o      <= 1'b0;
    end else begin
      buf_we_o <= hs_a || hs_b;
      done_o   <= 1'b0;

      // Address is the counter value before its increment.
      if (hs_a) begin
        buf_sel_o   <= SEL_A;
        buf_addr_o  <= addr_a;
        buf_wdata_o <= a_data_i;
      end else if (hs_b) begin
        buf_sel_o   <= SEL_B;
        buf_addr_o  <= addr_b;
        buf_wdata_o <= b_data_i;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            rem_a     <= words_a_i;
            rem_b     <= words_b_i;
            burst_cnt <= '0;
            if (words_a_i != 16'd0) begin
              state <= GRANT_A;
            end else if (words_b_i != 16'd0) begin
              state <= GRANT_B;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        GRANT_A: begin
          if (hs_a) begin
            rem_a <= rem_next;
            if (burst_end) begin
              burst_cnt <= '0;
              if (rem_b != 16'd0) begin
                state <= GRANT_B;
              end else if (rem_next == 16'd0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end
        GRANT_B: begin
          if (hs_b) begin
            rem_b <= rem_next;
            if (burst_end) begin
              burst_cnt <= '0;
              if (rem_a != 16'd0) begin
                state <= GRANT_A;
              end else if (rem_next == 16'd0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_write_scheduler.sv
// Self-checking bench for buffer_write_scheduler.
// The reference model expands each job into its ordered list of buffer
// writes (round-robin bursts of at most BURST_LEN words); the monitor pops
// one expected write for every buf_we_o the design presents.
module tb_buffer_write_scheduler;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BL = 16;
  localparam int EW = 61;  // {last, sel, addr, data, count, half}

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [15:0]   words_a_i = '0, words_b_i = '0;
  logic          a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic [DW-1:0] a_data_i = '0, b_data_i = '0;
  logic          a_ready_o, b_ready_o;
  logic          buf_we_o, buf_sel_o;
  logic [AW-1:0] buf_addr_o;
  logic [DW-1:0] buf_wdata_o;
  logic [15:0]   count_a_o, count_b_o;
  logic          half_a_o, half_b_o, busy_o, done_o;
  logic [1:0]    state_dbg;

  buffer_write_scheduler #(
    .BUFFER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .words_a_i(words_a_i), .words_b_i(words_b_i),
    .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .buf_we_o(buf_we_o), .buf_sel_o(buf_sel_o), .buf_addr_o(buf_addr_o),
    .buf_wdata_o(buf_wdata_o), .count_a_o(count_a_o), .count_b_o(count_b_o),
    .half_a_o(half_a_o), .half_b_o(half_b_o), .busy_o(busy_o),
    .done_o(done_o), .state_o(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] a_q[$], b_q[$];
  int            zero_pending = 0;
  int            checks = 0;
  int            errors = 0;
  bit            full_valid = 1'b1;
  int            a_stall_after = -1;
  int            a_stall_left = 0;
  bit            a_stalling = 1'b0;
  int            a_sent = 0;
  bit            a_hs = 1'b0, b_hs = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expand a job into its write sequence and the words
  // each loader will offer.
  task automatic build_job(input int wa, input int wb);
    int            rem[2];
    int            cnt[2];
    int            side;
    int            total;
    int            n;
    logic [DW-1:0] w;
    logic [AW-1:0] ad;
    logic [15:0]   c16;
    logic          hf;
    rem[0] = wa; rem[1] = wb;
    cnt[0] = 0;  cnt[1] = 0;
    side  = (wa != 0) ? 0 : 1;
    total = wa + wb;
    if (total == 0) zero_pending++;
    while (rem[0] + rem[1] > 0) begin
      n = (rem[side] < BL) ? rem[side] : BL;
      for (int k = 0; k < n; k++) begin
        w = $urandom();
        if (side == 0) a_q.push_back(w);
        else           b_q.push_back(w);
        ad  = AW'(cnt[side] % (1 << AW));
        cnt[side]++;
        total--;
        c16 = 16'(cnt[side] % 65536);
        hf  = 1'((cnt[side] % 65536) / (1 << (AW - 1)) % 2);
        exp_q.push_back({(total == 0), (side == 1), ad, w, c16, hf});
      end
      rem[side] -= n;
      if (rem[1 - side] > 0) side = 1 - side;
    end
  endtask

  // ---------------- loader drivers ----------------
  always @(negedge clk) begin : loader_a
    logic [DW-1:0] tmp;
    if (!reset_n) begin
      a_valid_i = 1'b0; a_hs = 1'b0; a_stall_left = 0; a_stalling = 1'b0;
    end else begin
      if (a_hs && a_q.size() > 0) begin
        tmp = a_q.pop_front();
        a_sent++;
      end
      a_hs = 1'b0;
      if (a_stall_after >= 0 && a_sent == a_stall_after) begin
        a_stall_left  = 5;
        a_stall_after = -1;
      end
      a_stalling = (a_stall_left > 0);
      if (a_stalling) begin
        a_valid_i = 1'b0;
        a_stall_left--;
      end else if (a_q.size() > 0 && (full_valid || $urandom_range(0, 3) != 0)) begin
        a_valid_i = 1'b1;
        a_data_i  = a_q[0];
      end else begin
        a_valid_i = 1'b0;
      end
      #1;
      a_hs = a_valid_i && a_ready_o;
      if (a_stalling) begin
        check("stall_b_ready", 96'(b_ready_o), 96'(0));
        check("stall_a_grant_held", 96'(a_ready_o), 96'(1));
      end
    end
  end

  always @(negedge clk) begin : loader_b
    logic [DW-1:0] tmp;
    if (!reset_n) begin
      b_valid_i = 1'b0; b_hs = 1'b0;
    end else begin
      if (b_hs && b_q.size() > 0) tmp = b_q.pop_front();
      b_hs = 1'b0;
      if (b_q.size() > 0 && (full_valid || $urandom_range(0, 3) != 0)) begin
        b_valid_i = 1'b1;
        b_data_i  = b_q[0];
      end else begin
        b_valid_i = 1'b0;
      end
      #1;
      b_hs = b_valid_i && b_ready_o;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] act, e;
    if (reset_n) begin
      if (buf_we_o) begin
        act = {done_o, buf_sel_o, buf_addr_o, buf_wdata_o,
               (buf_sel_o ? count_b_o : count_a_o),
               (buf_sel_o ? half_b_o : half_a_o)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %0h expected no write", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL write{done,sel,addr,data,count,half}: got %0h expected %0h", act, e);
          end
        end
      end else if (done_o) begin
        checks++;
        if (zero_pending == 0) begin
          errors++;
          $display("FAIL done_without_write: got done=1 expected done=0");
        end else begin
          zero_pending--;
        end
      end
    end
  end

  // ---------------- job driver ----------------
  task automatic run_job(input int wa, input int wb, input bit full, input int stall,
                         input bit poke_start);
    int cycles;
    int budget;
    full_valid    = full;
    a_sent        = 0;
    a_stall_after = stall;
    build_job(wa, wb);
    budget = (wa + wb) * 8 + 50;
    @(negedge clk);
    words_a_i = 16'(wa);
    words_b_i = 16'(wb);
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cycles  = 1;
    while (!done_o && cycles < budget) begin
      @(negedge clk);
      cycles++;
      // A start while busy must be ignored, whatever the word inputs say.
      start_i = 1'b0;
      if (poke_start && cycles == 3 && busy_o && !done_o) begin
        start_i   = 1'b1;
        words_a_i = 16'd7;
        words_b_i = 16'd7;
      end
    end
    start_i = 1'b0;
    // Start is sampled in cycle 0, transfers fill cycles 1..N with no
    // bubbles, done shares the cycle of the last write.
    if (full) check($sformatf("done_latency_%0d_%0d", wa, wb), 96'(cycles),
                    96'(wa + wb + 1 + ((stall >= 0) ? 5 : 0)));
    else      check($sformatf("done_seen_%0d_%0d", wa, wb), 96'(done_o), 96'(1));
    @(negedge clk);
    check("job_drained", 96'(exp_q.size()), 96'(0));
    check("idle_after_done", 96'({busy_o, done_o, buf_we_o}), 96'(0));
    check("counts_retained", 96'({count_a_o, count_b_o}),
          96'({16'(wa % 65536), 16'(wb % 65536)}));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {buf_we_o, buf_sel_o, buf_addr_o, buf_wdata_o, count_a_o, count_b_o},
          96'(0));
    check({name, "_ctl"}, 96'({half_a_o, half_b_o, busy_o, done_o, a_ready_o,
                               b_ready_o, state_dbg}), 96'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int wa, wb;
    #3;
    check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    run_job(3, 2, 1'b1, -1, 1'b0);
    run_job(40, 40, 1'b1, -1, 1'b0);
    run_job(1100, 0, 1'b1, -1, 1'b0);
    run_job(20, 20, 1'b1, 4, 1'b0);
    run_job(0, 0, 1'b1, -1, 1'b0);
    run_job(0, 9, 1'b1, -1, 1'b0);

    // Reset in the middle of a burst: the job is dropped.
    full_valid = 1'b1;
    a_stall_after = -1;
    build_job(30, 30);
    @(negedge clk);
    words_a_i = 16'd30; words_b_i = 16'd30; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete(); a_q.delete(); b_q.delete();
    #1 check_reset_outputs("reset_mid_job");
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset_held");
    #1 reset_n = 1'b1;
    run_job(5, 3, 1'b1, -1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      wa = $urandom_range(0, 70);
      wb = $urandom_range(0, 70);
      run_job(wa, wb, 1'b0, -1, (wa + wb > 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
